// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the default iteration count.
package mdu_pkg;

    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Core <-> MDU connection: operation launch, MTHI/MTLO writes, status and HI/LO.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = ITER_COUNT
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate: operand magnitudes at latch and result
// sign fixup.
module mdu_abs_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);
    assign result = neg ? ((~value) + W'(1)) : value;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional MDU_EARLY_TERM_EN: multiplies leave CALC once the multiplier is exhausted.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = ITER_COUNT
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         state, state_nxt;
    logic [CW-1:0]      cnt;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               a_neg, b_neg, b_zero, dbz_q;
    logic [2*WIDTH-1:0] acc, mcand;

    logic               launch, busy_c, done_c, last_iter;
    logic               in_signed, in_div, q_div;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;

    assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign in_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign q_div     = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign launch    = bus.start && ((state == IDLE) || (state == DONE));

    mdu_abs_neg #(.W(WIDTH)) u_a_mag (
        .value (bus.a),
        .neg   (in_signed & bus.a[WIDTH-1]),
        .result(a_mag)
    );

    mdu_abs_neg #(.W(WIDTH)) u_b_mag (
        .value (bus.b),
        .neg   (in_signed & bus.b[WIDTH-1]),
        .result(b_mag)
    );

    mdu_abs_neg #(.W(2*WIDTH)) u_prod_fix (
        .value (acc),
        .neg   (a_neg ^ b_neg),
        .result(prod_fix)
    );

    mdu_abs_neg #(.W(WIDTH)) u_quo_fix (
        .value (mplier),
        .neg   (a_neg ^ b_neg),
        .result(quo_fix)
    );

    mdu_abs_neg #(.W(WIDTH)) u_rem_fix (
        .value (acc[WIDTH-1:0]),
        .neg   (a_neg),
        .result(rem_fix)
    );

    // Restoring divide: acc[WIDTH-1:0] is the partial remainder, mplier shifts
    // the dividend out at the top and collects quotient bits at the bottom.
    assign rem_sh  = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, mcand[WIDTH-1:0]};
    assign rem_sub = rem_sh[WIDTH-1:0] - mcand[WIDTH-1:0];

`ifdef MDU_EARLY_TERM_EN
    assign last_iter = (cnt == LAST) || (!q_div && (mplier[WIDTH-1:1] == '0));
`else
    assign last_iter = (cnt == LAST);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = CALC;
            end
            CALC: begin
                busy_c = 1'b1;
                if (last_iter) state_nxt = FIXUP;
            end
            FIXUP: begin
                busy_c    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = launch ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= OP_MULTU;
            a_raw  <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else begin
            dbz_q <= (state == FIXUP) && q_div && b_zero;
            if (launch) begin
                cnt    <= '0;
                op_q   <= mdu_op_e'(bus.op);
                a_raw  <= bus.a;
                a_neg  <= in_signed & bus.a[WIDTH-1];
                b_neg  <= in_signed & bus.b[WIDTH-1];
                b_zero <= (bus.b == '0);
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, (in_div ? b_mag : a_mag)};
                mplier <= in_div ? a_mag : b_mag;
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                if (q_div) begin
                    acc    <= {{WIDTH{1'b0}}, (rem_ge ? rem_sub : rem_sh[WIDTH-1:0])};
                    mplier <= {mplier[WIDTH-2:0], rem_ge};
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                end
            end else if (state == FIXUP) begin
                if (q_div) begin
                    if (b_zero) begin
                        hi_q <= a_raw;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end else begin
                    {hi_q, lo_q} <= prod_fix;
                end
            end else if (!busy_c && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic model of
// MULT/MULTU/DIV/DIVU, MTHI/MTLO, timing and reset abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; latency is CALC count + FIXUP + DONE.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l,
                                  output logic z, output int lat);
        longint      sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] m;
        int          n;
        z   = 1'b0;
        lat = 34;
        h   = '0;
        l   = '0;
        sx  = o[0] ? longint'($signed(x)) : longint'({32'h0, x});
        sy  = o[0] ? longint'($signed(y)) : longint'({32'h0, y});
        if (!o[1]) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'h0) begin
            h = x;
            l = 32'hFFFF_FFFF;
            z = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            h = r[31:0];
            l = q[31:0];
        end
`ifdef MDU_EARLY_TERM_EN
        if (!o[1]) begin
            m = (o[0] && y[31]) ? (32'h0 - y) : y;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            lat = n + 2;
        end
`else
        m = '0;
        n = 0;
`endif
    endfunction

    // Launch from a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // mode 1: start pulse at cycle 5 (must be ignored); mode 2: MT write at cycle 2 (dropped).
    task automatic wait_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                               input logic ez, input int lat, input int mode,
                               input logic [31:0] held_hi);
        int cyc      = 1;
        int busy_cnt = 0;
        bit seen     = 1'b0;
        while (1) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (mode == 1 && cyc == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'h1;
                bus.b     = 32'h1;
            end
            if (mode == 1 && cyc == 6) bus.start = 1'b0;
            if (mode == 2 && cyc == 2) begin
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (mode == 2 && cyc == 3) begin
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                check32({tag, ":busy_write_dropped"}, bus.hi, held_hi);
            end
            if (cyc >= 80) break;
            @(negedge clk);
            cyc++;
        end
        check1({tag, ":done_seen"}, seen, 1'b1);
        checki({tag, ":latency"}, cyc, lat);
        checki({tag, ":busy_cycles"}, busy_cnt, lat - 1);
        check1({tag, ":busy_at_done"}, bus.busy, 1'b0);
        check32({tag, ":hi"}, bus.hi, eh);
        check32({tag, ":lo"}, bus.lo, el);
        check1({tag, ":div_by_zero"}, bus.div_by_zero, ez);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check1({tag, ":done_pulse_end"}, bus.done, 1'b0);
        check1({tag, ":dbz_cleared"}, bus.div_by_zero, 1'b0);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input logic ez, input int mode);
        logic [31:0] mh, ml;
        logic        mz;
        int          lat;
        model(o, x, y, mh, ml, mz, lat);
        issue(o, x, y);
        wait_result(tag, eh, el, ez, lat, mode, 32'h0);
        after_done(tag);
    endtask

    initial begin
        logic [31:0] mh, ml, ra, rb;
        logic [1:0]  ro;
        logic        mz;
        int          lat, done_cnt;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset:busy", bus.busy, 1'b0);
        check1("reset:done", bus.done, 1'b0);
        check1("reset:dbz", bus.div_by_zero, 1'b0);
        check32("reset:hi", bus.hi, 32'h0);
        check32("reset:lo", bus.lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run("divu_zero", OP_DIVU, 32'h0000_0005, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 0);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
        run("div_zero_s", OP_DIV, 32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 0);
        run("divu_midstart", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1);

        // MTHI / MTLO in idle, both strobes, then a write colliding with start
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        check32("mt_both:hi", bus.hi, 32'h0BAD_F00D);
        check32("mt_both:lo", bus.lo, 32'h0BAD_F00D);
        bus.lo_we = 1'b0;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check32("mthi:hi", bus.hi, 32'h1234_5678);
        check32("mthi:lo_kept", bus.lo, 32'h0BAD_F00D);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        model(OP_MULTU, 32'd3, 32'd5, mh, ml, mz, lat);
        issue(OP_MULTU, 32'd3, 32'd5);
        check32("mtlo_vs_start:lo", bus.lo, 32'h0BAD_F00D);
        wait_result("mt_overwrite", 32'h0, 32'd15, 1'b0, lat, 2, 32'h1234_5678);
        after_done("mt_overwrite");

        // Back-to-back: start held during the DONE cycle
        model(OP_MULTU, 32'd6, 32'd7, mh, ml, mz, lat);
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_result("b2b_first", 32'h0, 32'd42, 1'b0, lat, 0, 32'h0);
        model(OP_DIVU, 32'd100, 32'd7, mh, ml, mz, lat);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_result("b2b_second", 32'd2, 32'd14, 1'b0, lat, 0, 32'h0);
        after_done("b2b_second");

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(ro, ra, rb, mh, ml, mz, lat);
            issue(ro, ra, rb);
            wait_result($sformatf("rand%0d_op%0d", i, ro), mh, ml, mz, lat, (i % 4 == 1) ? 1 : 0, 32'h0);
            after_done($sformatf("rand%0d", i));
        end

        // Reset mid-operation: second start ignored, no done, HI/LO cleared
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        check1("abort:busy_before_reset", bus.busy, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check1("abort:busy", bus.busy, 1'b0);
        check1("abort:done", bus.done, 1'b0);
        check32("abort:hi", bus.hi, 32'h0);
        check32("abort:lo", bus.lo, 32'h0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        checki("abort:no_done", done_cnt, 0);
        check32("abort:hi_after", bus.hi, 32'h0);

        model(OP_MULT, 32'hFFFF_FF00, 32'h0000_0100, mh, ml, mz, lat);
        issue(OP_MULT, 32'hFFFF_FF00, 32'h0000_0100);
        wait_result("post_reset", mh, ml, mz, lat, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
